feature_frame_loader: RTL and testbench

Upstream front end for the printed red-wine MLP classifier. The block accepts quantised features as a serial 4-bit stream with a valid/ready handshake and assembles 11 of them into the 44-bit feature word that drives the classifier's combinational input. It holds that word stable for a fixed settle window, samples the classifier's 3-bit class index, and presents the index downstream on a valid/ready handshake.

---
 rtl/feature_loader_pkg.sv | 10 +
 rtl/frame_settle_timer.sv | 22 ++
 rtl/feature_frame_loader.sv | 111 +++++++++++
 tb/tb_feature_frame_loader.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/feature_loader_pkg.sv
// Shared widths and FSM state type for the feature frame loader.
package feature_loader_pkg;
  localparam int DEF_N_FEAT  = 11;
  localparam int DEF_FEAT_W  = 4;
  localparam int DEF_CLS_W   = 3;
  localparam int FEAT_WORD_W = DEF_N_FEAT * DEF_FEAT_W;
  localparam int CNT_W       = $clog2(DEF_N_FEAT);

  typedef enum logic [1:0] {FILL, SETTLE, OUT} state_t;
endpackage

// File: rtl/frame_settle_timer.sv
// Loadable down-counter: load sets SETTLE_CYC-1, en decrements toward 0, zero flags 0.
module frame_settle_timer #(
  parameter int SETTLE_CYC = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic zero
);
  localparam int W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                cnt <= '0;
    else if (load)             cnt <= W'(SETTLE_CYC - 1);
    else if (en && cnt != '0)  cnt <= cnt - 1'b1;
  end

  assign zero = (cnt == '0);
endmodule

// File: rtl/feature_frame_loader.sv
// Serial feature beats -> held feature word -> sampled class on a valid/ready output.
// Optional framing check on s_first when LOADER_SYNC_EN is defined.
module feature_frame_loader
  import feature_loader_pkg::*;
#(
  parameter int N_FEAT     = DEF_N_FEAT,
  parameter int FEAT_W     = DEF_FEAT_W,
  parameter int CLS_W      = DEF_CLS_W,
  parameter int SETTLE_CYC = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [FEAT_W-1:0]        s_data,
`ifdef LOADER_SYNC_EN
  input  logic                     s_first,
`endif
  output logic [N_FEAT*FEAT_W-1:0] feat_o,
  input  logic [CLS_W-1:0]         cls_i,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [CLS_W-1:0]         m_class,
  output logic                     busy,
  output logic                     sync_err
);
  localparam int CW = (N_FEAT > 1) ? $clog2(N_FEAT) : 1;

  state_t                        state;
  logic [CW-1:0]                 cnt, ncnt, widx;
  logic [N_FEAT-1:0][FEAT_W-1:0] feat;
  logic                          acc, wr, done, settle_zero;

  assign feat_o  = feat;
  assign s_ready = (state == FILL);
  assign acc     = s_valid & s_ready;

`ifdef LOADER_SYNC_EN
  logic err;
`endif

  // Decide where an accepted beat lands; framing errors either restart or drop it.
  always_comb begin
    wr   = acc;
    widx = cnt;
    ncnt = cnt + 1'b1;
`ifdef LOADER_SYNC_EN
    err  = 1'b0;
    if (acc && s_first && cnt != '0) begin
      widx = '0;
      ncnt = CW'(1);
      err  = 1'b1;
    end else if (acc && !s_first && cnt == '0) begin
      wr   = 1'b0;
      ncnt = cnt;
      err  = 1'b1;
    end
`endif
    done = wr && (widx == CW'(N_FEAT - 1));
  end

  frame_settle_timer #(.SETTLE_CYC(SETTLE_CYC)) u_timer (
    .clk  (clk),
    .rst_n(rst_n),
    .load (done),
    .en   (state == SETTLE),
    .zero (settle_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= FILL;
      cnt     <= '0;
      feat    <= '0;
      m_class <= '0;
      m_valid <= 1'b0;
      busy    <= 1'b0;
    end else begin
      case (state)
        FILL: begin
          if (wr)  feat[widx] <= s_data;
          if (acc) cnt <= done ? '0 : ncnt;
          if (done) begin
            state <= SETTLE;
            busy  <= 1'b1;
          end
        end
        SETTLE: if (settle_zero) begin
          m_class <= cls_i;
          m_valid <= 1'b1;
          state   <= OUT;
        end
        OUT: if (m_ready) begin
          m_valid <= 1'b0;
          busy    <= 1'b0;
          state   <= FILL;
        end
        default: state <= FILL;
      endcase
    end
  end

`ifdef LOADER_SYNC_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_err <= 1'b0;
    else        sync_err <= err;
  end
`else
  assign sync_err = 1'b0;
`endif
endmodule

// File: tb/tb_feature_frame_loader.sv
// Randomized bench for feature_frame_loader against a beat/timestamp reference model.
module tb_feature_frame_loader;
  localparam int S = 4;

  logic        clk = 1'b0;
  logic        rst_n, s_valid, s_ready, m_valid, m_ready, busy, sync_err;
  logic [3:0]  s_data;
  logic [43:0] feat_o;
  logic [2:0]  cls_i, m_class;
`ifdef LOADER_SYNC_EN
  logic        s_first;
`endif

  int checks = 0, errors = 0, cyc = 0;

  // reference model: beats collected, cycles since the frame completed, output pending
  int          nb = 0, since = -1;
  bit          outv = 0, merr = 0, last_acc = 0;
  logic [43:0] word = '0;
  logic [2:0]  mcls = '0;
  int          acc_cyc[$];

  feature_frame_loader #(.SETTLE_CYC(S)) dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
`ifdef LOADER_SYNC_EN
    .s_first(s_first),
`endif
    .feat_o(feat_o), .cls_i(cls_i), .m_valid(m_valid), .m_ready(m_ready),
    .m_class(m_class), .busy(busy), .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic bit idle();
    return (since < 0) && !outv;
  endfunction

  task automatic store(input logic [3:0] d);
    word[4*nb +: 4] = d;
    nb++;
    if (nb == 11) begin
      nb    = 0;
      since = 0;
    end
  endtask

  task automatic tick();
    bit acc;
    acc  = s_valid && idle();
    merr = 0;
    if (outv && m_ready) outv = 0;
    else if (since >= 0) begin
      since++;
      if (since == S) begin
        mcls  = cls_i;
        outv  = 1;
        since = -1;
      end
    end
    if (acc) begin
`ifdef LOADER_SYNC_EN
      if (s_first && nb != 0) begin
        word[3:0] = s_data;
        nb = 1;
        merr = 1;
      end else if (!s_first && nb == 0) merr = 1;
      else store(s_data);
`else
      store(s_data);
`endif
    end
    last_acc = acc;
    @(posedge clk);
    #1;
    cyc++;
    if (acc) acc_cyc.push_back(cyc);
    chk("s_ready", s_ready, idle());
    chk("m_valid", m_valid, outv);
    chk("busy", busy, (since >= 0) || outv);
    chk("feat_o", feat_o, word);
    chk("m_class", m_class, mcls);
    chk("sync_err", sync_err, merr);
  endtask

  task automatic beat(input logic [3:0] d);
    s_valid = 1;
    s_data  = d;
`ifdef LOADER_SYNC_EN
    s_first = (nb == 0);
`endif
    tick();
  endtask

  task automatic model_reset();
    nb = 0; since = -1; outv = 0; merr = 0; word = '0; mcls = '0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_feat"}, feat_o, 0);
    chk({tag, "_mvalid"}, m_valid, 0);
    chk({tag, "_mclass"}, m_class, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_syncerr"}, sync_err, 0);
    chk({tag, "_sready"}, s_ready, 1);
  endtask

  // bring the model (and DUT) to an empty FILL state
  task automatic drain();
    m_ready = 1;
    for (int i = 0; i < 60 && !(idle() && nb == 0); i++) begin
      if (idle()) beat(4'($urandom));
      else begin
        s_valid = 0;
        tick();
      end
    end
    s_valid = 0;
    chk("drain", idle() && nb == 0, 1);
  endtask

  initial begin
    rst_n = 0; s_valid = 0; s_data = 0; cls_i = 0; m_ready = 0;
`ifdef LOADER_SYNC_EN
    s_first = 0;
`endif
    #12;
    chk_reset("rst");
    @(negedge clk) rst_n = 1;

    // directed frame: beats 1..11, class 5
    cls_i = 3'b101;
    for (int i = 1; i <= 11; i++) beat(4'(i));
    s_valid = 0;
    chk("sready_after_last", s_ready, 0);
    repeat (S - 1) tick();
    chk("mvalid_early", m_valid, 0);
    tick();
    chk("mvalid_latency", m_valid, 1);
    chk("class_5", m_class, 3'd5);
    chk("word_const", feat_o, 44'hBA987654321);

    // hold in OUT with m_ready low and stray s_valid pulses
    for (int i = 0; i < 10; i++) begin
      s_valid = 1'($urandom);
      s_data  = 4'($urandom);
      cls_i   = 3'($urandom);
      tick();
    end
    chk("hold_word", feat_o, 44'hBA987654321);
    chk("hold_class", m_class, 3'd5);
    chk("hold_valid", m_valid, 1);
    s_valid = 0; m_ready = 1;
    tick();
    chk("release_mvalid", m_valid, 0);
    chk("release_sready", s_ready, 1);

    // back-to-back frames with m_ready tied high
    acc_cyc.delete();
    for (int i = 0; i < 40; i++) beat(4'($urandom));
    s_valid = 0;
    chk("accepts", acc_cyc.size() >= 12, 1);
    if (acc_cyc.size() >= 12) begin
      chk("period", acc_cyc[11] - acc_cyc[0], 16);
      chk("beat_gap", acc_cyc[1] - acc_cyc[0], 1);
    end

    // reset mid-frame after six beats
    drain();
    for (int i = 0; i < 6; i++) beat(4'($urandom));
    s_valid = 0;
    #2 rst_n = 0;
    #1 chk_reset("midrst");
    model_reset();
    @(negedge clk) rst_n = 1;
    for (int i = 0; i < 11; i++) beat(4'(i + 3));
    s_valid = 0; m_ready = 0;
    repeat (S) tick();
    chk("post_rst_valid", m_valid, 1);
    chk("post_rst_word", feat_o, 44'hDCBA9876543);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      s_valid = ($urandom_range(0, 3) != 0);
      s_data  = 4'($urandom);
      cls_i   = 3'($urandom);
      m_ready = ($urandom_range(0, 2) == 0);
`ifdef LOADER_SYNC_EN
      s_first = ($urandom_range(0, 14) == 0) ? (nb != 0) : (nb == 0);
`endif
      tick();
    end

`ifdef LOADER_SYNC_EN
    // resync: s_first on beat 4
    drain();
    m_ready = 0;
    for (int i = 0; i < 3; i++) beat(4'(i + 1));
    s_valid = 1; s_data = 4'hE; s_first = 1;
    tick();
    chk("resync_err", sync_err, 1);
    chk("resync_slot0", feat_o[3:0], 4'hE);
    s_first = 0;
    for (int i = 0; i < 10; i++) begin
      s_data = 4'($urandom);
      tick();
      if (i == 0) chk("resync_err_once", sync_err, 0);
    end
    s_valid = 0;
    chk("resync_busy", busy, 1);
    repeat (S) tick();
    chk("resync_done", m_valid, 1);

    // drop: first beat of a frame without s_first
    drain();
    s_valid = 1; s_data = 4'h7; s_first = 0;
    tick();
    chk("drop_err", sync_err, 1);
    s_valid = 0;
    tick();
    chk("drop_err_clear", sync_err, 0);
    chk("drop_cnt", nb, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
